// File: rtl/dm_bytelane.sv
// dm_bytelane: byte-lane data memory for the MEM stage of the pipelined MIPS core.
//
// Byte, halfword and word loads/stores with byte-lane write masking. Loads are
// sign- or zero-extended and returned through a registered one-cycle read path.
// Misaligned and out-of-range accesses return err=1 with rdata=0 and never write.
// After reset a clear sequencer zeroes the array one word per cycle.
//
// Handshake: ready=1 in RUN. A request is accepted on a rising edge of clk when
// ready && req_valid. Its response (rvalid pulse, rdata, err) is presented during
// the following cycle. There is no backpressure on the response side. Requests
// while ready=0 are ignored.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req_valid       access request
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10/11 word
//   req_unsigned    zero-extend byte/half loads
//   pc              instruction PC (store trace only)
//   addr            byte address
//   wdata           right-aligned store data
//   ready           accepting requests (RUN state)
//   rvalid          one-cycle response pulse
//   rdata           extended load data (0 for stores and errors)
//   err             one-cycle pulse with rvalid: misaligned or out of range
//   init_busy       clear sequence in progress (INIT state)
module dm_bytelane #(
  parameter int DEPTH  = 3072,
  parameter int IDX_W  = 12,
  parameter bit LOG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        init_busy
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_V  = (IDX_W+1)'(DEPTH);

  state_t           state, state_nx;
  logic [IDX_W-1:0] clr_idx, clr_idx_nx;

  logic [31:0] mem [DEPTH];

  // Request decode
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             misaligned, out_of_range, bad, accept, do_wr;

  assign idx  = addr[IDX_W+1:2];
  assign lane = addr[1:0];

  assign misaligned   = ((req_size == 2'b01) && addr[0]) ||
                        (req_size[1] && (lane != 2'b00));
  assign out_of_range = ({1'b0, idx} >= DEPTH_V);
  assign bad          = misaligned || out_of_range;
  assign accept       = (state == S_RUN) && req_valid;
  assign do_wr        = accept && req_we && !bad;

  // Out-of-range indices never reach the array.
  logic [31:0] rd_word;
  assign rd_word = out_of_range ? 32'h0 : mem[idx];

  // Store lane enables and replicated data
  logic [3:0]  be;
  logic [31:0] wd_rep, mask, merged;

  always_comb begin
    be     = 4'b1111;
    wd_rep = wdata;
    case (req_size)
      2'b00: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be     = addr[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = wdata;
      end
    endcase
  end

  assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  // Full word after the store; written back as one word so only enabled bytes change.
  assign merged = (rd_word & ~mask) | (wd_rep & mask);

  // Load extraction and extension
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_val;

  always_comb begin
    case (lane)
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_size)
      2'b00:   ld_val = req_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_val = req_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_val = rd_word;
    endcase
  end

  // FSM next state: INIT walks the clear index up to DEPTH-1, then RUN.
  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    case (state)
      S_INIT: begin
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_nx   = S_RUN;
          clr_idx_nx = '0;
        end
      end
      default: begin
        state_nx   = S_RUN;
        clr_idx_nx = clr_idx;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_INIT;
      clr_idx <= '0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
      rvalid  <= accept;
      err     <= accept && bad;
      if (accept) begin
        rdata <= (bad || req_we) ? 32'h0 : ld_val;
      end
    end
  end

  // Single write port shared by the clear sequencer and stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT) begin
        mem[clr_idx] <= 32'h0;
      end else if (do_wr) begin
        mem[idx] <= merged;
      end
    end
  end

  assign ready     = (state == S_RUN);
  assign init_busy = (state == S_INIT);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (LOG_EN && !reset && do_wr) begin
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
module tb_dm_bytelane;

  localparam int DEPTH = 3072;
  localparam int IDX_W = 12;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] pc, addr, wdata;
  logic        ready, rvalid, err, init_busy;
  logic [31:0] rdata;

  dm_bytelane #(.DEPTH(DEPTH), .IDX_W(IDX_W), .LOG_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .pc(pc), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err),
    .init_busy(init_busy)
  );

  // Scoreboard state: {err, rdata}
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  logic [31:0] last_exp;
  int          vectors = 0;
  int          miscompares = 0;
  bit          run_phase = 1'b0;

  // Reference model: flat byte-addressed memory
  logic [7:0] mbytes [DEPTH*4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [32:0] model_access(input bit we, input logic [1:0] size,
                                               input bit uns, input logic [31:0] a,
                                               input logic [31:0] wd);
    int n, widx, base;
    logic [31:0] v;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    widx = int'(a[IDX_W+1:2]);
    base = widx * 4 + int'(a[1:0]);
    if ((int'(a[1:0]) % n) != 0 || widx >= DEPTH) return {1'b1, 32'h0};
    if (we) begin
      for (int k = 0; k < n; k++) mbytes[base + k] = wd[8*k +: 8];
      return {1'b0, 32'h0};
    end
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mbytes[base + k];
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return {1'b0, v};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0, 1:    a = 32'($urandom_range(0, 63));
      2:       a = 32'h2FF0 + 32'($urandom_range(0, 31));
      default: a = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 127));
    endcase
    return a;
  endfunction

  // Driver tasks (called at a negedge, return at the next negedge)
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    addr = a; wdata = wd; pc = pc + 32'd4;
    if (run_phase) begin
      chk("ready", 32'(ready), 32'd1);
      exp_q.push_back(model_access(we, size, uns, a, wd));
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Assert reset for one edge (optionally alongside a load), then follow the
  // clear sequence. abort_at > 0 returns early at that clear index.
  task automatic reset_seq(input bit with_load, input int abort_at);
    int cnt;
    run_phase = 1'b0;
    reset = 1'b1;
    if (with_load) begin
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; addr = 32'h10;
    end
    @(posedge clk); #1;
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst init_busy", 32'(init_busy), 32'd1);
    chk("rst ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < DEPTH*4; i++) mbytes[i] = 8'h0;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < DEPTH + 16) begin
      if (abort_at > 0 && cnt == abort_at) begin
        req_valid = 1'b0;
        return;
      end
      // Requests during the clear must be ignored.
      req_valid = 1'($urandom_range(0, 1)); req_we = 1'b1; req_size = 2'd2;
      addr = rand_addr(); wdata = $urandom();
      chk("init ready low", 32'(ready), 32'd0);
      cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("init cycles", 32'(cnt), 32'(DEPTH));
    chk("ready after init", 32'(ready), 32'd1);
    run_phase = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      last_exp = 32'h0;
    end else if (rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected rvalid", 32'(rvalid), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("rdata", rdata, exp_e[31:0]);
        chk("err", 32'(err), 32'(exp_e[32]));
        last_exp = exp_e[31:0];
      end
    end else begin
      chk("idle err", 32'(err), 32'd0);
      chk("rdata hold", rdata, last_exp);
    end
  end

  // Watchdog
  initial begin
    #2ms;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; pc = 32'h0040_0000; addr = 32'h0; wdata = 32'h0;
    last_exp = 32'h0;
    @(negedge clk);

    // Clear sequence, then prove a second clear wipes written data.
    reset_seq(1'b0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h2FFC, 32'h5A5A_A5A5);
    issue(1'b1, 2'd2, 1'b0, 32'h0000, 32'h1111_2222);
    issue(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0);
    idle(2);
    reset_seq(1'b0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000, 32'h0);

    // Word store / load back-to-back
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    // Byte lanes
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    // Halfword
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_BABE);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    // Errors, then confirm memory unchanged
    issue(1'b1, 2'd2, 1'b0, 32'h11, 32'hFFFF_FFFF);
    issue(1'b0, 2'd1, 1'b0, 32'h21, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h3001, 32'h55);
    issue(1'b1, 2'd1, 1'b0, 32'h23, 32'h7777);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), rand_addr(), $urandom());
    end
    idle(2);

    // Reset on the same edge as a load: no response, full clear.
    reset_seq(1'b1, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF);
    issue(1'b1, 2'd2, 1'b0, 32'h2FFC, 32'hBEEF_DEAD);
    idle(1);

    // Reset at clear index 100, then a full clear from index 0.
    reset_seq(1'b0, 0);
    reset_seq(1'b0, 100);
    reset_seq(1'b0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0);
    idle(3);

    chk("queue drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
